// File: rtl/core_pkg.sv
// core_pkg: shared scoreboard constants, operand bit order, issue record and hazard helper.
package core_pkg;
  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int LAT_W     = 4;
  localparam int MAX_LAT   = 15;
  localparam int RS1_B = 2;
  localparam int RS2_B = 1;
  localparam int RS3_B = 0;
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
    logic                 fpu_reg_write;
    logic [LAT_W-1:0]     lat;
  } issue_t;
  // A count of 1 means the result is at W next cycle, where forwarding covers it.
  function automatic logic src_hazard(input logic used, input logic fp,
                                      input logic [LAT_W-1:0] int_cnt,
                                      input logic [LAT_W-1:0] fpu_cnt);
    return used && ((fp ? fpu_cnt : int_cnt) >= LAT_W'(2));
  endfunction
endpackage

// File: rtl/sb_counter_bank.sv
// sb_counter_bank: one register file's remaining-latency counters with load,
// self-decrement and source/destination read ports.
module sb_counter_bank
  import core_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CW       = 4,
  localparam int IW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ld_en,
  input  logic [IW-1:0]       ld_idx,
  input  logic [CW-1:0]       ld_val,
  input  logic [IW-1:0]       src_idx [3],
  output logic [CW-1:0]       src_cnt [3],
  input  logic [IW-1:0]       dst_idx,
  output logic [CW-1:0]       dst_cnt,
  output logic [NUM_REGS-1:0] busy
);
  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = (ld_en && ld_idx == IW'(i)) ? ld_val :
                 (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : cnt_q[i];
      busy[i]  = cnt_q[i] != '0;
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) src_cnt[k] = cnt_q[src_idx[k]];
    dst_cnt = cnt_q[dst_idx];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= '{default: '0};
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard: DP-stage write hazard tracker for integer and FP register files;
// stalls on unforwardable RAW and on WAW reordering, then records the issue.
module fpu_scoreboard
  import core_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = 4,
  parameter int MAX_LAT  = 15,
  localparam int IW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [IW-1:0]       rs1_dp,
  input  logic [IW-1:0]       rs2_dp,
  input  logic [IW-1:0]       rs3_dp,
  input  logic [2:0]          rs_fpu_dp,
  input  logic [2:0]          rs_used_dp,
  input  logic                issue_valid_dp,
  input  logic [IW-1:0]       rd_dp,
  input  logic                reg_write_dp,
  input  logic                fpu_reg_write_dp,
  input  logic [LAT_W-1:0]    lat_dp,
  input  logic                flush,
  output logic                stall_dp,
  output logic                raw_hazard,
  output logic                waw_hazard,
  output logic [NUM_REGS-1:0] busy_int,
  output logic [NUM_REGS-1:0] busy_fpu
);
  logic [IW-1:0]    src_idx [3];
  logic [LAT_W-1:0] i_src   [3];
  logic [LAT_W-1:0] f_src   [3];
  logic [LAT_W-1:0] i_dst, f_dst;
  logic             raw_any, waw_any, gate, commit;
  issue_t           iss;

  always_comb begin
    src_idx[0] = rs1_dp;
    src_idx[1] = rs2_dp;
    src_idx[2] = rs3_dp;
    iss.rd            = rd_dp;
    iss.reg_write     = reg_write_dp;
    iss.fpu_reg_write = fpu_reg_write_dp;
    iss.lat           = (lat_dp > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : lat_dp;
    raw_any = src_hazard(rs_used_dp[RS1_B], rs_fpu_dp[RS1_B], i_src[0], f_src[0]) ||
              src_hazard(rs_used_dp[RS2_B], rs_fpu_dp[RS2_B], i_src[1], f_src[1]) ||
              src_hazard(rs_used_dp[RS3_B], rs_fpu_dp[RS3_B], i_src[2], f_src[2]);
    // x0 never loads, so its counter stays 0 and it is naturally WAW-exempt.
    waw_any = (iss.reg_write && i_dst > lat_dp) || (iss.fpu_reg_write && f_dst > lat_dp);
    gate       = issue_valid_dp && !flush;
    raw_hazard = gate && raw_any;
    waw_hazard = gate && waw_any;
    stall_dp   = raw_hazard || waw_hazard;
    commit     = gate && !stall_dp;
  end

  sb_counter_bank #(.NUM_REGS(NUM_REGS), .CW(LAT_W)) u_int (
    .clk     (clk),
    .rstn    (rstn),
    .ld_en   (commit && iss.reg_write && iss.rd != '0),
    .ld_idx  (iss.rd),
    .ld_val  (iss.lat),
    .src_idx (src_idx),
    .src_cnt (i_src),
    .dst_idx (iss.rd),
    .dst_cnt (i_dst),
    .busy    (busy_int)
  );

  sb_counter_bank #(.NUM_REGS(NUM_REGS), .CW(LAT_W)) u_fpu (
    .clk     (clk),
    .rstn    (rstn),
    .ld_en   (commit && iss.fpu_reg_write),
    .ld_idx  (iss.rd),
    .ld_val  (iss.lat),
    .src_idx (src_idx),
    .src_cnt (f_src),
    .dst_idx (iss.rd),
    .dst_cnt (f_dst),
    .busy    (busy_fpu)
  );
endmodule

// File: tb/tb_fpu_scoreboard.sv
// tb_fpu_scoreboard: directed self-checking bench with hand-computed expectations.
module tb_fpu_scoreboard;
  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  rs1_dp, rs2_dp, rs3_dp, rd_dp;
  logic [2:0]  rs_fpu_dp, rs_used_dp;
  logic        issue_valid_dp, reg_write_dp, fpu_reg_write_dp, flush;
  logic [3:0]  lat_dp;
  logic        stall_dp, raw_hazard, waw_hazard;
  logic [31:0] busy_int, busy_fpu;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpu_scoreboard dut (
    .clk(clk), .rstn(rstn),
    .rs1_dp(rs1_dp), .rs2_dp(rs2_dp), .rs3_dp(rs3_dp),
    .rs_fpu_dp(rs_fpu_dp), .rs_used_dp(rs_used_dp),
    .issue_valid_dp(issue_valid_dp), .rd_dp(rd_dp),
    .reg_write_dp(reg_write_dp), .fpu_reg_write_dp(fpu_reg_write_dp),
    .lat_dp(lat_dp), .flush(flush),
    .stall_dp(stall_dp), .raw_hazard(raw_hazard), .waw_hazard(waw_hazard),
    .busy_int(busy_int), .busy_fpu(busy_fpu)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                     input logic [2:0] fp, input logic [2:0] used, input logic [4:0] rd,
                     input logic w, input logic fw, input logic [3:0] lat, input logic fl);
    issue_valid_dp = v; rs1_dp = a; rs2_dp = b; rs3_dp = c;
    rs_fpu_dp = fp; rs_used_dp = used; rd_dp = rd;
    reg_write_dp = w; fpu_reg_write_dp = fw; lat_dp = lat; flush = fl;
    #2;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    tick(); tick();
    chk("reset_busy_fpu", busy_fpu, 0);
    chk("reset_busy_int", busy_int, 0);
    chk("reset_stall", {31'd0, stall_dp}, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Basic RAW: fdiv f5, L=6
    drv(1, 0, 0, 0, 3'b000, 3'b000, 5, 0, 1, 6, 0);
    chk("raw_issue_nostall", {31'd0, stall_dp}, 0);
    tick();
    drv(1, 5, 0, 0, 3'b100, 3'b100, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("raw_stall_c%0d", k), {30'd0, stall_dp, raw_hazard}, 2'b11);
      tick();
      #2;
    end
    chk("raw_release_c6", {30'd0, stall_dp, raw_hazard}, 0);
    chk("raw_busy_c6", busy_fpu, 32'h20);
    tick();
    idle();
    chk("raw_busy_drained", busy_fpu, 0);

    // x0 immunity and file separation
    drv(1, 0, 0, 0, 3'b000, 3'b000, 0, 1, 0, 5, 0);
    chk("x0_issue_nostall", {31'd0, stall_dp}, 0);
    tick();
    idle();
    chk("x0_not_busy", busy_int, 0);
    drv(1, 0, 0, 0, 3'b000, 3'b100, 0, 0, 0, 0, 0);
    chk("x0_read_nostall", {31'd0, stall_dp}, 0);
    drv(1, 0, 0, 0, 3'b000, 3'b000, 5, 0, 1, 4, 0);
    tick();
    drv(1, 5, 0, 0, 3'b000, 3'b100, 0, 0, 0, 0, 0);
    chk("int_x5_vs_f5_nostall", {31'd0, stall_dp}, 0);
    drv(1, 0, 5, 0, 3'b010, 3'b010, 0, 0, 0, 0, 0);
    chk("rs2_f5_stall", {30'd0, stall_dp, raw_hazard}, 2'b11);
    drv(1, 0, 0, 5, 3'b001, 3'b000, 0, 0, 0, 0, 0);
    chk("rs3_unused_nostall", {31'd0, stall_dp}, 0);
    idle();
    tick(); tick(); tick(); tick();
    chk("f5_drained", busy_fpu, 0);

    // WAW ordering: f3 L=8, then fadd f3 L=2 when cnt=6
    drv(1, 0, 0, 0, 3'b000, 3'b000, 3, 0, 1, 8, 0);
    tick();
    idle();
    tick(); tick();
    drv(1, 0, 0, 0, 3'b000, 3'b000, 3, 0, 1, 2, 0);
    for (int k = 6; k >= 3; k--) begin
      chk($sformatf("waw_stall_cnt%0d", k), {29'd0, stall_dp, waw_hazard, raw_hazard}, 3'b110);
      tick();
      #2;
    end
    chk("waw_release_cnt2", {29'd0, stall_dp, waw_hazard, raw_hazard}, 0);
    tick();
    drv(1, 3, 0, 0, 3'b100, 3'b100, 0, 0, 0, 0, 0);
    chk("waw_reload_cnt2_raw", {31'd0, stall_dp}, 1);
    tick();
    #2;
    chk("waw_reload_cnt1_noraw", {31'd0, stall_dp}, 0);
    idle();
    tick();
    chk("waw_f3_drained", busy_fpu, 0);

    // Flush squash: f9 L=10 pending; stalled instr reading f9 writing f7
    drv(1, 0, 0, 0, 3'b000, 3'b000, 9, 0, 1, 10, 0);
    tick();
    drv(1, 9, 0, 0, 3'b100, 3'b100, 7, 0, 1, 3, 0);
    chk("flush_pre_stall", {31'd0, stall_dp}, 1);
    drv(1, 9, 0, 0, 3'b100, 3'b100, 7, 0, 1, 3, 1);
    chk("flush_gates", {29'd0, stall_dp, raw_hazard, waw_hazard}, 0);
    tick();
    idle();
    chk("flush_no_f7", busy_fpu, 32'h200);
    for (int k = 0; k < 8; k++) tick();
    chk("flush_f9_cnt1", busy_fpu, 32'h200);
    tick();
    chk("flush_f9_drained", busy_fpu, 0);

    // Single-cycle op with immediate dependent
    drv(1, 0, 0, 0, 3'b000, 3'b000, 4, 1, 0, 1, 0);
    tick();
    drv(1, 0, 4, 0, 3'b000, 3'b010, 0, 0, 0, 0, 0);
    chk("l1_dep_nostall", {31'd0, stall_dp}, 0);
    chk("l1_busy_one_cycle", busy_int, 32'h10);
    tick();
    idle();
    chk("l1_cleared", busy_int, 0);

    // Both write flags load both files
    drv(1, 0, 0, 0, 3'b000, 3'b000, 6, 1, 1, 3, 0);
    tick();
    idle();
    chk("dual_busy_int", busy_int, 32'h40);
    chk("dual_busy_fpu", busy_fpu, 32'h40);
    tick(); tick();

    // Async reset mid-run with f5 pending at 7
    drv(1, 0, 0, 0, 3'b000, 3'b000, 5, 0, 1, 7, 0);
    tick();
    drv(1, 5, 0, 0, 3'b100, 3'b100, 0, 0, 0, 0, 0);
    chk("rst_pre_busy", busy_fpu, 32'h20);
    chk("rst_pre_stall", {31'd0, stall_dp}, 1);
    rstn = 1'b0;
    #1;
    chk("rst_async_busy", busy_fpu, 0);
    chk("rst_async_stall", {31'd0, stall_dp}, 0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("rst_after_release_busy", busy_fpu, 0);
    chk("rst_after_release_stall", {31'd0, stall_dp}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_scoreboard.md
Name: fpu_scoreboard

Overview:
- Write-side hazard tracker paired with the pipeline's operand-forwarding logic.
- Records every issued instruction's destination register and remaining result latency, for the integer and FP register files separately.
- Stalls the DP stage while a source operand is still too far from writeback to be forwarded, and on write-after-write ordering hazards.
- Sits beside the DP stage; consumes the same rs1/rs2/rs3 and rs_fpu operand encoding as the forwarding path.

Parameters:
- NUM_REGS, 32, registers per file (int and FP); index width is $clog2(NUM_REGS).
- LAT_W, 4, width of per-register remaining-latency counter.
- MAX_LAT, 15, largest legal issue latency; must be ≤ 2**LAT_W-1.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- rs1_dp  in  5  source 1 index.
- rs2_dp  in  5  source 2 index.
- rs3_dp  in  5  source 3 index.
- rs_fpu_dp  in  3  [2]=rs1 is FP, [1]=rs2 is FP, [0]=rs3 is FP.
- rs_used_dp  in  3  same bit order; 1 = source actually read.
- issue_valid_dp  in  1  DP holds a valid instruction.
- rd_dp  in  5  destination index.
- reg_write_dp  in  1  writes integer rd.
- fpu_reg_write_dp  in  1  writes FP rd.
- lat_dp  in  LAT_W  cycles until the result reaches W (0/1 = single-cycle class).
- flush  in  1  squash the DP instruction this cycle.
- stall_dp  out  1  hold DP/IF this cycle.
- raw_hazard  out  1  stall cause is RAW.
- waw_hazard  out  1  stall cause is WAW.
- busy_int  out  NUM_REGS  per-register pending-write bitmap (counter ≥ 1), integer file.
- busy_fpu  out  NUM_REGS  per-register pending-write bitmap (counter ≥ 1), FP file.

Behaviour:
- State:
  - cnt_int[NUM_REGS] and cnt_fpu[NUM_REGS], LAT_W bits each.
  - Reset (async, rstn=0): all counters 0, so all outputs are 0.
- Decrement: every cycle, each nonzero counter decrements by 1 unless it is reloaded by an issue that same cycle.
- RAW, per source i: stall when used[i] && cnt[file(i)][rs_i] ≥ 2.
  - file(i) is selected by rs_fpu_dp bit.
  - Integer rs = 0 never hazards.
  - cnt == 1 is not a hazard: the result is at W next cycle and is covered by W-stage forwarding.
- WAW: stall when issue_valid_dp && write && cnt[file][rd_dp] > lat_dp.
  - This prevents an older, slower write from landing after a younger one.
  - Integer rd = 0 is exempt.
- Outputs:
  - stall_dp = issue_valid_dp && !flush && (raw_hazard || waw_hazard).
  - raw_hazard and waw_hazard are gated identically.
- Issue commit: occurs when issue_valid_dp && !flush && !stall_dp.
  - reg_write_dp && rd_dp != 0: cnt_int[rd_dp] ← lat_dp on the next edge.
  - fpu_reg_write_dp: cnt_fpu[rd_dp] ← lat_dp on the next edge.
  - Both write flags set: both files load (legal, e.g. move ops).
  - Reload takes priority over decrement for that entry.
  - lat_dp > MAX_LAT is clamped to MAX_LAT.
- Timing:
  - Issue at edge t with latency L gives cnt = L in cycle t+1 and reaches 1 in cycle t+L.
  - A dependent in DP stalls from cycle t+1 through t+L-1, and proceeds in cycle t+L.
- Stall is combinational from DP inputs and registered counters; there is no combinational path from flush to the counters other than the issue gate.
- Flush never clears counters: issued instructions always complete.
- A source reading the same register the instruction writes is evaluated against the pre-issue counter.
- Reset mid-operation clears all tracking immediately, regardless of clk.

Decomposition:
- Shared package core_pkg:
  - LAT_W, MAX_LAT, and the REG_IDX_W constant.
  - The rs_fpu bit-order localparams (RS1_B = 2, RS2_B = 1, RS3_B = 0).
  - An issue_t struct {rd, reg_write, fpu_reg_write, lat}.
- One sub-module, sb_counter_bank:
  - One register file's counter array, with decrement, load port, and three read ports.
  - Instantiated twice (int and FP).

Test Plan:
- Reset check: rstn low mid-run with cnt_fpu[5] = 7 → busy_fpu = 0 and stall_dp = 0 immediately; first edge after release still shows 0.
- Basic RAW: issue fdiv f5, L = 6 at cycle 0; next instruction reads f5 (rs_fpu = 3'b100) → stall_dp = 1 and raw_hazard = 1 for cycles 1–5, stall_dp = 0 in cycle 6.
- x0 immunity: issue int write rd = 0, L = 5 → busy_int = 0; a later read of x0 never stalls. Also, an int read of x5 while only f5 is busy → no stall.
- WAW ordering: f3 issued with L = 8; at cnt = 6, issue fadd f3 with L = 2 → waw_hazard = 1 until cnt ≤ 2, then commits and cnt_fpu[3] = 2.
- Flush squash: stalled DP instruction writing f7 with flush = 1 → stall_dp = 0 and cnt_fpu[7] unchanged; independent pending counters keep decrementing.
- Single-cycle ops: issue with L = 1 then an immediate dependent → no stall ever; cnt reads 1 for one cycle, then 0.
